// File: rtl/obr_pkg.sv
// Shared types for the one-bit register and its downstream deserializer.
package obr_pkg;

  localparam int OBR_WIDTH_DEF = 8;

  typedef logic [$clog2(OBR_WIDTH_DEF)-1:0] cnt_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/obr_deserializer_if.sv
// Serial-in / word-out bundle for obr_deserializer.
// Output handshake: a word transfers on the rising edge where word_valid & word_ready;
// word_out is stable while word_valid=1, and word_valid never depends on word_ready.
interface obr_deserializer_if
  import obr_pkg::*;
#(
  parameter int WIDTH = OBR_WIDTH_DEF
) ();

  localparam int CW = $clog2(WIDTH);

  logic             bit_in;
  logic             bit_valid;
  logic             flush;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [CW-1:0]    bit_count;
  logic             overrun;

  modport slave (
    input  bit_in, bit_valid, flush, word_ready,
    output word_out, word_valid, bit_count, overrun
  );

  modport master (
    output bit_in, bit_valid, flush, word_ready,
    input  word_out, word_valid, bit_count, overrun
  );

endinterface

// File: rtl/obr_word_buf.sv
// Single-entry valid/ready output buffer with a sticky overrun flag for dropped words.
module obr_word_buf
  import obr_pkg::*;
#(
  parameter int WIDTH = OBR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic             o_overrun,
  output buf_state_t       o_state
);

  buf_state_t       r_state;
  buf_state_t       w_state_next;
  logic [WIDTH-1:0] r_word;
  logic             r_overrun;
  logic             w_load_word;
  logic             w_drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_next;
  end

  // A completion while full is only absorbed if the old word leaves on the same edge.
  always_comb begin
    w_state_next = r_state;
    w_load_word  = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      EMPTY: begin
        if (i_load) begin
          w_state_next = FULL;
          w_load_word  = 1'b1;
        end
      end
      FULL: begin
        if (i_load && i_ready) begin
          w_load_word = 1'b1;
        end else if (i_load) begin
          w_drop = 1'b1;
        end else if (i_ready) begin
          w_state_next = EMPTY;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_word <= '0;
    else if (w_load_word) r_word <= i_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_overrun <= 1'b0;
    else if (i_flush) r_overrun <= 1'b0;
    else if (w_drop)  r_overrun <= 1'b1;
  end

  assign o_word    = r_word;
  assign o_valid   = (r_state == FULL);
  assign o_overrun = r_overrun;
  assign o_state   = r_state;

endmodule

// File: rtl/obr_deserializer.sv
// Assembles WIDTH-bit words from a qualified serial bit stream and hands them to
// a single-entry output buffer.
module obr_deserializer
  import obr_pkg::*;
#(
  parameter int WIDTH     = OBR_WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  obr_deserializer_if.slave   bus,
  output buf_state_t          o_buf_state
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [CW-1:0]    r_count;
  logic             w_accept;
  logic             w_complete;

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shift_next = {r_shift[WIDTH-2:0], bus.bit_in};
    end else begin : g_lsb
      assign w_shift_next = {bus.bit_in, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // flush swallows a coincident bit, so it can never complete a word.
  assign w_accept   = bus.bit_valid & ~bus.flush;
  assign w_complete = w_accept & (r_count == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_shift <= w_shift_next;
      r_count <= w_complete ? '0 : r_count + 1'b1;
    end
  end

  obr_word_buf #(
    .WIDTH (WIDTH)
  ) u_word_buf (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_complete),
    .i_word    (w_shift_next),
    .i_ready   (bus.word_ready),
    .i_flush   (bus.flush),
    .o_word    (bus.word_out),
    .o_valid   (bus.word_valid),
    .o_overrun (bus.overrun),
    .o_state   (o_buf_state)
  );

  assign bus.bit_count = r_count;

endmodule

// File: tb/tb_obr_deserializer.sv
// Bench for obr_deserializer: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_obr_deserializer;
  import obr_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic tb_bit, tb_valid, tb_flush, tb_ready;

  obr_deserializer_if #(.WIDTH(W)) if_msb ();
  obr_deserializer_if #(.WIDTH(W)) if_lsb ();

  assign if_msb.bit_in     = tb_bit;
  assign if_msb.bit_valid  = tb_valid;
  assign if_msb.flush      = tb_flush;
  assign if_msb.word_ready = tb_ready;
  assign if_lsb.bit_in     = tb_bit;
  assign if_lsb.bit_valid  = tb_valid;
  assign if_lsb.flush      = tb_flush;
  assign if_lsb.word_ready = tb_ready;

  buf_state_t st_msb, st_lsb;

  obr_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk         (clk),
    .reset       (reset),
    .bus         (if_msb),
    .o_buf_state (st_msb)
  );

  obr_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk         (clk),
    .reset       (reset),
    .bus         (if_lsb),
    .o_buf_state (st_lsb)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_lsb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset && if_msb.word_valid && tb_ready) begin
      check("msb_sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("msb_word", if_msb.word_out, exp_q.pop_front());
    end
    if (!reset && if_lsb.word_valid && tb_ready) begin
      check("lsb_sb_nonempty", 32'(exp_lsb_q.size() != 0), 32'd1);
      if (exp_lsb_q.size() != 0) check("lsb_word", if_lsb.word_out, exp_lsb_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic b, input logic v, input logic f);
    tb_bit   = b;
    tb_valid = v;
    tb_flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit keep);
    if (keep) begin
      exp_q.push_back(w);
      exp_lsb_q.push_back(rev(w));
    end
    for (int i = W - 1; i >= 0; i--) drive(w[i], 1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] w;
    reset    = 1'b1;
    tb_bit   = 1'b0;
    tb_valid = 1'b0;
    tb_flush = 1'b0;
    tb_ready = 1'b0;
    #1;
    check("rst_word_out", if_msb.word_out, 32'h0);
    check("rst_valid", if_msb.word_valid, 32'h0);
    check("rst_count", if_msb.bit_count, 32'h0);
    check("rst_overrun", if_msb.overrun, 32'h0);
    check("rst_state", st_msb, EMPTY);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // basic word, A5
    tb_ready = 1'b1;
    send_word(8'hA5, 1'b1);
    check("t1_valid", if_msb.word_valid, 32'h1);
    check("t1_word", if_msb.word_out, 32'hA5);
    check("t1_count", if_msb.bit_count, 32'h0);
    idle();
    check("t1_valid_one_cycle", if_msb.word_valid, 32'h0);
    check("t1_overrun", if_msb.overrun, 32'h0);

    // bit order
    send_word(8'hC0, 1'b1);
    check("t2_msb_word", if_msb.word_out, 32'hC0);
    check("t2_lsb_word", if_lsb.word_out, 32'h03);
    idle();

    // gaps between bits hold the counter
    w = 8'h5A;
    exp_q.push_back(w);
    exp_lsb_q.push_back(rev(w));
    for (int i = W - 1; i >= 0; i--) begin
      drive(w[i], 1'b1, 1'b0);
      drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      check("t3_count_hold", if_msb.bit_count, 32'((W - i) % W));
    end
    idle();

    // back-pressure overrun
    tb_ready = 1'b0;
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b0);
    check("t4_overrun", if_msb.overrun, 32'h1);
    check("t4_word_kept", if_msb.word_out, 32'h11);
    check("t4_valid", if_msb.word_valid, 32'h1);
    tb_ready = 1'b1;
    idle();
    check("t4_valid_drop", if_msb.word_valid, 32'h0);
    check("t4_overrun_sticky", if_msb.overrun, 32'h1);
    drive(1'b0, 1'b0, 1'b1);
    check("t4_overrun_flushed", if_msb.overrun, 32'h0);

    // replace without bubble
    tb_ready = 1'b0;
    send_word(8'hF0, 1'b1);
    w = 8'h0F;
    exp_q.push_back(w);
    exp_lsb_q.push_back(rev(w));
    for (int i = W - 1; i >= 1; i--) drive(w[i], 1'b1, 1'b0);
    tb_ready = 1'b1;
    drive(w[0], 1'b1, 1'b0);
    check("t5_valid", if_msb.word_valid, 32'h1);
    check("t5_word", if_msb.word_out, 32'h0F);
    check("t5_overrun", if_msb.overrun, 32'h0);
    idle();
    check("t5_drained", if_msb.word_valid, 32'h0);

    // flush discards partial word and the coincident bit
    for (int i = 0; i < 3; i++) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    check("t6_count3", if_msb.bit_count, 32'h3);
    drive(1'b1, 1'b1, 1'b1);
    check("t6_flush_count", if_msb.bit_count, 32'h0);
    send_word(8'h81, 1'b1);
    check("t6_word", if_msb.word_out, 32'h81);
    idle();

    // async reset mid-word with a word pending
    tb_ready = 1'b0;
    send_word(8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
    check("t6_pending_valid", if_msb.word_valid, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_word_out", if_msb.word_out, 32'h0);
    check("ar_valid", if_msb.word_valid, 32'h0);
    check("ar_count", if_msb.bit_count, 32'h0);
    check("ar_overrun", if_msb.overrun, 32'h0);
    check("ar_lsb_valid", if_lsb.word_valid, 32'h0);
    check("ar_state", st_msb, EMPTY);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();

    check("sb_msb_empty", exp_q.size(), 32'h0);
    check("sb_lsb_empty", exp_lsb_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obr_deserializer.md
# obr_deserializer

Downstream stage of the one-bit write-enabled register. Consumes the register's serial output one qualified bit per clock, assembles WIDTH-bit words, and presents each completed word on a single-entry valid/ready output buffer. Detects and flags words lost to back-pressure.

## Interface
- WIDTH, 8: bits per assembled word; legal range 2..32.
- MSB_FIRST, 1: 1 = first accepted bit lands in word_out[WIDTH-1]; 0 = first bit lands in word_out[0].

- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- bit_in  in  1  serial data from the one-bit register output.
- bit_valid  in  1  qualifies bit_in this cycle; it is the register's write enable delayed one cycle.
- flush  in  1  synchronous; discards the partial word and clears overrun.
- word_out  out  WIDTH  assembled word; stable while word_valid=1.
- word_valid  out  1  output buffer holds a word.
- word_ready  in  1  consumer accepts word_out when word_valid & word_ready.
- bit_count  out  $clog2(WIDTH)  bits accepted into the current partial word.
- overrun  out  1  sticky; a completed word was dropped.

## Operation
- Reset values: word_out=0, word_valid=0, bit_count=0, overrun=0, shift register=0.
- Accept: bit_valid=1 at an edge stores bit_in into the shift register and increments bit_count. With MSB_FIRST=1 it shifts left, inserting at bit 0. With MSB_FIRST=0 it shifts right, inserting at bit WIDTH-1.
- Completion: the accept with bit_count=WIDTH-1 completes a word.
  - The complete word is formed from the shift register plus the incoming bit.
  - bit_count wraps to 0 on that edge.
- Output buffer FSM, two states:
  - EMPTY (word_valid=0): on completion, load word_out and go to FULL.
  - FULL (word_valid=1): on word_ready=1 with no completion, go to EMPTY. word_out keeps its old value, which is don't-care.
  - FULL, completion with word_ready=1 in the same cycle: load the new word and stay FULL. No bubble, no overrun.
  - FULL, completion with word_ready=0: drop the new word, keep the old one, set overrun.
- bit_valid=0: shift register and bit_count hold.
- flush=1:
  - bit_count and the shift register clear, and overrun clears.
  - flush has priority over a simultaneous bit_valid; that bit is discarded.
  - The output buffer is not affected, and a handshake in the same cycle still completes.
- overrun is cleared only by reset or flush.
- reset asserted mid-word or with word_valid=1 drops everything immediately, with no clock required.

## Timing
- Latency: the edge that accepts the last bit sets word_valid. word_valid and word_out are visible in the following cycle.
- Throughput: one bit per clock. A word every WIDTH cycles is sustained when word_ready is held high.
- The handshake completes at the rising edge where word_valid & word_ready are both 1. word_valid falls after that edge unless a new word completes on the same edge.
- word_valid has no combinational path to word_ready. All outputs are registered.
- reset deassertion takes effect at the first edge after release. Inputs are ignored while reset=1.

## Structure
- Shared package obr_pkg:
  - OBR_WIDTH_DEF = 8.
  - cnt_t type for bit_count, sized by $clog2.
  - buf_state_t enum {EMPTY, FULL}.
- The one-bit register and this block share the package.
- Natural sub-module: obr_word_buf.
  - Holds the single-entry valid/ready buffer and the overrun flag.
  - The top level holds the shift register and the counter.

## Test plan
All scenarios use WIDTH=8, MSB_FIRST=1 unless stated.
1. Reset then serial 1,0,1,0,0,1,0,1 with bit_valid=1 and word_ready=1 -> word_valid for exactly one cycle, word_out=8'hA5, bit_count back to 0, overrun=0.
2. MSB_FIRST=0, same bit stream -> word_out=8'hA5 bit-reversed = 8'hA5 with 8'h3C used instead to check: stream 0,0,1,1,1,1,0,0 gives 8'h3C for both orders, so use 1,1,0,0,0,0,0,0 -> MSB_FIRST=1 gives 8'hC0, MSB_FIRST=0 gives 8'h03.
3. bit_valid toggled 1,0,1,0 between bits of 8'h5A -> word_out=8'h5A; bit_count holds during gaps.
4. word_ready=0, send 8'h11 then 8'h22 -> word_out stays 8'h11, overrun=1 after the 16th bit. Then word_ready=1 -> word_valid drops. Then flush -> overrun=0.
5. Back-to-back 8'hF0 and 8'h0F with word_ready=1 only on the 16th bit's edge -> 8'h0F replaces 8'hF0 with no bubble, overrun=0.
6. After 3 bits, assert flush with bit_valid=1, then send 8'h81 -> word_out=8'h81. Separately, async reset mid-word with word_valid=1 -> all outputs 0 before the next edge.
